// File: rtl/vs_mailbox_pkg.sv
// vs_mailbox_pkg: shared constants for the host/core mailbox.
// Host register offsets, core addresses, signature value and the
// FLAGS / IRQ_STAT bit positions live here so every file agrees on them.
package vs_mailbox_pkg;

  // Host (Wishbone) word offsets
  localparam logic [3:0] HOST_DATA     = 4'd0;
  localparam logic [3:0] HOST_STATUS   = 4'd1;
  localparam logic [3:0] HOST_FLAGS    = 4'd2;
  localparam logic [3:0] HOST_IRQ_EN   = 4'd3;
  localparam logic [3:0] HOST_IRQ_STAT = 4'd4;
  localparam logic [3:0] HOST_CTRL     = 4'd5;
  localparam logic [3:0] HOST_SIG      = 4'd15;

  // Core-side addresses
  localparam logic CORE_DATA   = 1'b0;
  localparam logic CORE_STATUS = 1'b1;

  localparam logic [31:0] SIGNATURE = 32'h4d42_0001;

  // FLAGS bit indices
  localparam int FLAG_H2C_OVF = 0;
  localparam int FLAG_C2H_UDF = 1;

  // IRQ_STAT bit indices
  localparam int IRQ_C2H_AVAIL = 0;
  localparam int IRQ_H2C_DRAIN = 1;
  localparam int IRQ_ERR       = 2;

  // Offsets 6..14 are holes in the map and answer with an error.
  function automatic logic host_adr_ok(input logic [3:0] adr);
    return (adr <= HOST_CTRL) || (adr == HOST_SIG);
  endfunction

endpackage

// File: rtl/vs_mailbox_if.sv
// vs_mailbox_if: Wishbone (pipelined) host bus of the mailbox.
// Handshake: a request is any cycle with wbs_cyc & wbs_stb; the slave never
// stalls and answers every request exactly one cycle later with a one-cycle
// wbs_ack (or wbs_err for an unmapped offset), wbs_dat_r valid with it.
interface vs_mailbox_if;
  logic [3:0]  wbs_adr;
  logic [31:0] wbs_dat_w;
  logic [31:0] wbs_dat_r;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc;
  logic        wbs_stb;
  logic        wbs_we;
  logic        wbs_ack;
  logic        wbs_stall;
  logic        wbs_err;

  modport master (
    output wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  wbs_dat_r, wbs_ack, wbs_stall, wbs_err
  );

  modport slave (
    input  wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output wbs_dat_r, wbs_ack, wbs_stall, wbs_err
  );
endinterface

// File: rtl/vs_mailbox_fifo.sv
// mailbox_fifo: single-clock FIFO with wrapping pointers and a level counter.
// Push on full is accepted only when a pop frees a slot in the same cycle;
// pop on empty is ignored. Flush empties the FIFO and overrides push/pop.
module mailbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Pointer and level bookkeeping; flush wins over any traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/vs_mailbox.sv
// vs_mailbox: host<->core mailbox with H2C and C2H FIFOs.
// Host side is a Wishbone slave (vs_mailbox_if), core side a simple
// rd/wr port. Interrupt logic exists only when VS_MAILBOX_IRQ_EN is defined;
// otherwise irq_out is 0 and IRQ_EN/IRQ_STAT read as 0.
module vs_mailbox
  import vs_mailbox_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  vs_mailbox_if.slave wbs,
  input  logic        core_addr,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        irq_out
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              host_req, host_ok, host_wr, host_rd;
  logic              h2c_push, h2c_pop, c2h_push, c2h_pop, flush;
  logic [DATA_W-1:0] h2c_rdata, c2h_rdata;
  logic [LVL_W-1:0]  h2c_level, c2h_level;
  logic              h2c_full, h2c_empty, c2h_full, c2h_empty;
  logic              host_ovf, host_udf, core_ovf, core_udf;
  logic [1:0]        flags;
  logic              ctrl_q;
  logic [2:0]        irq_en, irq_stat;
  logic              ack_q, err_q;
  logic [31:0]       dat_r_q, host_rdata;
  logic              unused_ok;

  assign host_req = wbs.wbs_cyc & wbs.wbs_stb;
  assign host_ok  = host_adr_ok(wbs.wbs_adr);
  assign host_wr  = host_req & host_ok & wbs.wbs_we;
  assign host_rd  = host_req & host_ok & ~wbs.wbs_we;

  assign h2c_push = host_wr & (wbs.wbs_adr == HOST_DATA);
  assign c2h_pop  = host_rd & (wbs.wbs_adr == HOST_DATA);
  assign flush    = host_wr & (wbs.wbs_adr == HOST_CTRL) & wbs.wbs_dat_w[0];
  assign h2c_pop  = core_rd & (core_addr == CORE_DATA);
  assign c2h_push = core_wr & (core_addr == CORE_DATA);

  // Dropped pushes and empty pops; none of them count during a flush.
  assign host_ovf = h2c_push & h2c_full & ~h2c_pop & ~flush;
  assign host_udf = c2h_pop & c2h_empty & ~flush;
  assign core_ovf = c2h_push & c2h_full & ~c2h_pop & ~flush;
  assign core_udf = h2c_pop & h2c_empty & ~flush;

  mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_h2c (
    .clk(sys_clk), .rst_n(rst_n), .push(h2c_push), .pop(h2c_pop),
    .flush(flush), .wdata(wbs.wbs_dat_w[DATA_W-1:0]), .rdata(h2c_rdata),
    .level(h2c_level), .full(h2c_full), .empty(h2c_empty)
  );

  mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_c2h (
    .clk(sys_clk), .rst_n(rst_n), .push(c2h_push), .pop(c2h_pop),
    .flush(flush), .wdata(core_wdata[DATA_W-1:0]), .rdata(c2h_rdata),
    .level(c2h_level), .full(c2h_full), .empty(c2h_empty)
  );

  // Host read data mux; empty DATA reads return 0.
  always_comb begin
    host_rdata = '0;
    case (wbs.wbs_adr)
      HOST_DATA:     host_rdata = c2h_empty ? '0 : 32'(c2h_rdata);
      HOST_STATUS:   host_rdata = {16'(c2h_level), 16'(h2c_level)};
      HOST_FLAGS:    host_rdata = {30'b0, flags};
      HOST_IRQ_EN:   host_rdata = {29'b0, irq_en};
      HOST_IRQ_STAT: host_rdata = {29'b0, irq_stat};
      HOST_CTRL:     host_rdata = {31'b0, ctrl_q};
      HOST_SIG:      host_rdata = SIGNATURE;
      default:       host_rdata = '0;
    endcase
  end

  // Bus response: one-cycle ack/err and registered read data.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      ack_q   <= host_req & host_ok;
      err_q   <= host_req & ~host_ok;
      dat_r_q <= host_rd ? host_rdata : '0;
    end
  end

  assign wbs.wbs_ack   = ack_q;
  assign wbs.wbs_err   = err_q;
  assign wbs.wbs_dat_r = dat_r_q;
  assign wbs.wbs_stall = 1'b0;

  // FLAGS (W1C, a set in the same cycle wins) and self-clearing CTRL.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= '0;
      ctrl_q <= 1'b0;
    end else begin
      flags  <= (flags & ~((host_wr && wbs.wbs_adr == HOST_FLAGS) ?
                           wbs.wbs_dat_w[1:0] : 2'b00))
                | {host_udf, host_ovf};
      ctrl_q <= flush;
    end
  end

  // Core read port: registered, holds its value between reads.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata <= '0;
    end else if (core_rd) begin
      if (core_addr == CORE_DATA) core_rdata <= h2c_empty ? '0 : 32'(h2c_rdata);
      else                        core_rdata <= {30'b0, ~c2h_full, ~h2c_empty};
    end
  end

`ifdef VS_MAILBOX_IRQ_EN
  logic [2:0] irq_set, irq_clr;
  logic       irq_q;

  assign irq_set[IRQ_C2H_AVAIL] = c2h_push & c2h_empty & ~flush;
  assign irq_set[IRQ_H2C_DRAIN] = ~h2c_empty &
      (flush | ((h2c_level == LVL_W'(1)) & h2c_pop & ~h2c_push));
  assign irq_set[IRQ_ERR]       = host_ovf | host_udf | core_ovf | core_udf;
  assign irq_clr = (host_wr && wbs.wbs_adr == HOST_IRQ_STAT) ?
                   wbs.wbs_dat_w[2:0] : 3'b000;

  // Interrupt enable/status registers and the registered level output.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en   <= '0;
      irq_stat <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (host_wr && wbs.wbs_adr == HOST_IRQ_EN) irq_en <= wbs.wbs_dat_w[2:0];
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      irq_q    <= |(irq_en & irq_stat);
    end
  end

  assign irq_out   = irq_q;
  assign unused_ok = ^{wbs.wbs_sel, wbs.wbs_dat_w, core_wdata};
`else
  assign irq_en    = '0;
  assign irq_stat  = '0;
  assign irq_out   = 1'b0;
  assign unused_ok = ^{wbs.wbs_sel, wbs.wbs_dat_w, core_wdata, core_ovf, core_udf};
`endif

endmodule

// File: tb/tb_vs_mailbox.sv
// tb_vs_mailbox: directed bench for vs_mailbox (DATA_W=8, DEPTH=16).
// Works with or without VS_MAILBOX_IRQ_EN; interrupt expectations follow it.
module tb_vs_mailbox;

`ifdef VS_MAILBOX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam logic [3:0] A_DATA = 4'd0, A_STATUS = 4'd1, A_FLAGS = 4'd2;
  localparam logic [3:0] A_IRQ_EN = 4'd3, A_IRQ_STAT = 4'd4, A_CTRL = 4'd5;
  localparam logic [3:0] A_SIG = 4'd15;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_addr = 1'b0, core_rd = 1'b0, core_wr = 1'b0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        irq_out;

  vs_mailbox_if wb();

  vs_mailbox #(.DATA_W(8), .DEPTH(16)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wbs(wb),
    .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .irq_out(irq_out)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // host expectations: {is_err, check_data, data}
  logic [33:0] exp_q[$];
  logic [31:0] core_exp_q[$];
  logic [33:0] mon_e;
  logic        core_rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // host monitor: every response is matched against the expected queue
  always @(negedge sys_clk) begin
    if (wb.wbs_ack || wb.wbs_err) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected_resp", {30'b0, wb.wbs_err, wb.wbs_ack}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_err", {31'b0, wb.wbs_err}, {31'b0, mon_e[33]});
        check("wb_ack", {31'b0, wb.wbs_ack}, {31'b0, ~mon_e[33]});
        if (mon_e[32]) check("wb_dat_r", wb.wbs_dat_r, mon_e[31:0]);
      end
    end
  end

  // core monitor: core_rdata checked the cycle after core_rd
  always @(posedge sys_clk) core_rd_seen <= core_rd & rst_n;
  always @(negedge sys_clk) begin
    if (core_rd_seen) begin
      if (core_exp_q.size() == 0) check("core_unexpected_rd", 32'h1, 32'h0);
      else                        check("core_rdata", core_rdata, core_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wb_xfer(input logic we, input logic [3:0] adr,
                         input logic [31:0] data, input logic [33:0] exp);
    @(negedge sys_clk);
    wb.wbs_cyc = 1'b1; wb.wbs_stb = 1'b1; wb.wbs_we = we;
    wb.wbs_adr = adr;  wb.wbs_dat_w = data; wb.wbs_sel = 4'hf;
    exp_q.push_back(exp);
    @(negedge sys_clk);
    wb.wbs_cyc = 1'b0; wb.wbs_stb = 1'b0; wb.wbs_we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] data);
    wb_xfer(1'b1, adr, data, {2'b00, 32'h0});
  endtask

  task automatic wb_read(input logic [3:0] adr, input logic [31:0] exp);
    wb_xfer(1'b0, adr, 32'h0, {2'b01, exp});
  endtask

  task automatic wb_bad(input logic we, input logic [3:0] adr);
    wb_xfer(we, adr, 32'h0000_0001, {2'b10, 32'h0});
  endtask

  task automatic core_write(input logic [31:0] data);
    @(negedge sys_clk);
    core_addr = 1'b0; core_wr = 1'b1; core_wdata = data;
    @(negedge sys_clk);
    core_wr = 1'b0;
  endtask

  task automatic core_read(input logic addr, input logic [31:0] exp);
    @(negedge sys_clk);
    core_addr = addr; core_rd = 1'b1;
    core_exp_q.push_back(exp);
    @(negedge sys_clk);
    core_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.wbs_cyc = 1'b0; wb.wbs_stb = 1'b0; wb.wbs_we = 1'b0;
    wb.wbs_adr = '0;   wb.wbs_dat_w = '0; wb.wbs_sel = '0;

    // reset state
    repeat (3) @(negedge sys_clk);
    check("rst_ack", {31'b0, wb.wbs_ack}, 32'h0);
    check("rst_err", {31'b0, wb.wbs_err}, 32'h0);
    check("rst_dat_r", wb.wbs_dat_r, 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_irq", {31'b0, irq_out}, 32'h0);
    check("rst_stall", {31'b0, wb.wbs_stall}, 32'h0);
    rst_n = 1'b1;

    wb_read(A_SIG, 32'h4d42_0001);
    wb_read(A_STATUS, 32'h0);
    wb_read(A_FLAGS, 32'h0);

    // host -> core basic transfer
    wb_write(A_DATA, 32'h41);
    wb_write(A_DATA, 32'h42);
    core_read(1'b1, 32'h3);
    core_read(1'b0, 32'h41);
    core_read(1'b0, 32'h42);
    core_read(1'b1, 32'h2);
    wb_read(A_IRQ_STAT, IRQ_ON ? 32'h2 : 32'h0);
    wb_write(A_IRQ_STAT, 32'h7);

    // H2C overflow: 17 pushes, 16 kept
    for (int i = 0; i < 17; i++) wb_write(A_DATA, 32'h10 + i);
    wb_read(A_STATUS, 32'h0000_0010);
    wb_read(A_FLAGS, 32'h1);
    for (int i = 0; i < 16; i++) core_read(1'b0, 32'h10 + i);
    core_read(1'b0, 32'h0);
    wb_read(A_STATUS, 32'h0);
    wb_read(A_DATA, 32'h0);
    wb_read(A_FLAGS, 32'h3);
    wb_read(A_IRQ_STAT, IRQ_ON ? 32'h6 : 32'h0);
    wb_write(A_FLAGS, 32'h1);
    wb_read(A_FLAGS, 32'h2);
    wb_write(A_FLAGS, 32'h2);
    wb_read(A_FLAGS, 32'h0);
    wb_write(A_IRQ_STAT, 32'h7);
    wb_read(A_IRQ_STAT, 32'h0);

    // interrupt timing
    wb_write(A_IRQ_EN, 32'h1);
    core_write(32'h55);
    check("irq_after_1", {31'b0, irq_out}, 32'h0);
    @(negedge sys_clk);
    check("irq_after_2", {31'b0, irq_out}, {31'b0, IRQ_ON});
    wb_write(A_IRQ_STAT, 32'h1);
    check("irq_clr_ack", {31'b0, irq_out}, {31'b0, IRQ_ON});
    @(negedge sys_clk);
    check("irq_clr_next", {31'b0, irq_out}, 32'h0);
    wb_read(A_IRQ_EN, IRQ_ON ? 32'h1 : 32'h0);
    wb_write(A_IRQ_EN, 32'h0);
    wb_read(A_DATA, 32'h55);

    // full C2H with simultaneous push and pop
    for (int i = 0; i < 16; i++) core_write(32'h80 + i);
    core_read(1'b1, 32'h0);
    wb_read(A_STATUS, 32'h0010_0000);
    wb_write(A_IRQ_STAT, 32'h7);
    @(negedge sys_clk);
    core_addr = 1'b0; core_wr = 1'b1; core_wdata = 32'h99;
    wb.wbs_cyc = 1'b1; wb.wbs_stb = 1'b1; wb.wbs_we = 1'b0; wb.wbs_adr = A_DATA;
    exp_q.push_back({2'b01, 32'h80});
    @(negedge sys_clk);
    core_wr = 1'b0; wb.wbs_cyc = 1'b0; wb.wbs_stb = 1'b0;
    wb_read(A_STATUS, 32'h0010_0000);
    wb_read(A_FLAGS, 32'h0);
    wb_read(A_IRQ_STAT, 32'h0);
    for (int i = 1; i < 16; i++) wb_read(A_DATA, 32'h80 + i);
    wb_read(A_DATA, 32'h99);
    wb_read(A_STATUS, 32'h0);

    // empty H2C with simultaneous push and pop
    @(negedge sys_clk);
    core_addr = 1'b0; core_rd = 1'b1; core_exp_q.push_back(32'h0);
    wb.wbs_cyc = 1'b1; wb.wbs_stb = 1'b1; wb.wbs_we = 1'b1;
    wb.wbs_adr = A_DATA; wb.wbs_dat_w = 32'h77;
    exp_q.push_back({2'b00, 32'h0});
    @(negedge sys_clk);
    core_rd = 1'b0; wb.wbs_cyc = 1'b0; wb.wbs_stb = 1'b0; wb.wbs_we = 1'b0;
    wb_read(A_STATUS, 32'h1);
    wb_read(A_IRQ_STAT, IRQ_ON ? 32'h4 : 32'h0);
    wb_read(A_FLAGS, 32'h0);
    core_read(1'b0, 32'h77);

    // unmapped offsets: error, no side effects
    wb_bad(1'b0, 4'd7);
    wb_bad(1'b1, 4'd10);
    wb_bad(1'b1, 4'd6);
    wb_read(A_STATUS, 32'h0);
    wb_read(A_SIG, 32'h4d42_0001);

    // set beats W1C clear on the same cycle
    wb_write(A_IRQ_STAT, 32'h7);
    @(negedge sys_clk);
    core_addr = 1'b0; core_rd = 1'b1; core_exp_q.push_back(32'h0);
    wb.wbs_cyc = 1'b1; wb.wbs_stb = 1'b1; wb.wbs_we = 1'b1;
    wb.wbs_adr = A_IRQ_STAT; wb.wbs_dat_w = 32'h4;
    exp_q.push_back({2'b00, 32'h0});
    @(negedge sys_clk);
    core_rd = 1'b0; wb.wbs_cyc = 1'b0; wb.wbs_stb = 1'b0; wb.wbs_we = 1'b0;
    wb_read(A_IRQ_STAT, IRQ_ON ? 32'h4 : 32'h0);

    // reset mid-transfer with 5 entries in H2C
    wb_write(A_IRQ_EN, 32'h4);
    @(negedge sys_clk);
    check("irq_before_rst", {31'b0, irq_out}, {31'b0, IRQ_ON});
    for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'hc0 + i);
    wb_read(A_STATUS, 32'h5);
    core_read(1'b1, 32'h3);
    @(negedge sys_clk);
    wb.wbs_cyc = 1'b1; wb.wbs_stb = 1'b1; wb.wbs_we = 1'b0; wb.wbs_adr = A_STATUS;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, wb.wbs_ack}, 32'h0);
    check("mid_rst_irq", {31'b0, irq_out}, 32'h0);
    check("mid_rst_core_rdata", core_rdata, 32'h0);
    check("mid_rst_dat_r", wb.wbs_dat_r, 32'h0);
    @(negedge sys_clk);
    wb.wbs_cyc = 1'b0; wb.wbs_stb = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    wb_read(A_STATUS, 32'h0);
    wb_read(A_IRQ_EN, 32'h0);
    core_read(1'b0, 32'h0);

    // flush with 3 entries in H2C
    for (int i = 0; i < 3; i++) wb_write(A_DATA, 32'he0 + i);
    core_write(32'h33);
    wb_read(A_STATUS, 32'h0001_0003);
    wb_write(A_CTRL, 32'h1);
    wb_read(A_STATUS, 32'h0);
    core_read(1'b1, 32'h2);
    core_read(1'b0, 32'h0);
    wb_read(A_DATA, 32'h0);

    // report
    repeat (4) @(negedge sys_clk);
    check("wb_pending", 32'(exp_q.size()), 32'h0);
    check("core_pending", 32'(core_exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
